// File: rtl/string_streamer_if.sv
// string_streamer_if
//   Byte stream from the message streamer to its sink (normally the UART
//   transmitter).
//
// Handshake: a byte moves on every rising clock edge where tx_valid and
// tx_ready are both high. While tx_valid is high and tx_ready is low, the
// source holds tx_data and tx_valid stable. tx_valid never depends on
// tx_ready. The sink may raise or lower tx_ready at any time.
//
// Signals
//   tx_data   8  source -> sink  current character
//   tx_valid  1  source -> sink  tx_data holds a character
//   tx_ready  1  sink -> source  sink takes tx_data this cycle
interface string_streamer_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/string_streamer.sv
// string_streamer
//   Message ROM with a built-in byte sequencer. A start strobe in IDLE
//   latches a message id. The module then streams that message over the
//   tx byte interface, starting with the first character. Ids at or above
//   MSG_COUNT send nothing and end with done and err pulsed together.
//
// Optional feature (macro STRING_STREAMER_CRLF_EN)
//   When this macro is defined, every valid message is followed by 8'h0D
//   and then 8'h0A. These bytes come from an extra TAIL state. When the
//   macro is undefined, the TAIL state does not exist.
//
// Ports
//   clk        in   1     rising-edge clock
//   rst_n      in   1     synchronous reset, active low
//   start      in   1     request strobe, looked at only in IDLE
//   id         in   ID_W  message select, sampled with start
//   tx         master     byte stream (tx_data / tx_valid / tx_ready)
//   busy       out  1     message being transmitted (SEND or TAIL)
//   done       out  1     one-cycle pulse when the message is finished
//   err        out  1     one-cycle pulse with done for an invalid id
//   dbg_state  out  2     FSM state: 0 IDLE, 1 SEND, 2 FIN, 3 TAIL
module string_streamer #(
  parameter int MSG_COUNT = 4,
  parameter int MAX_LEN   = 32,
  parameter int ID_W      = (MSG_COUNT > 1) ? $clog2(MSG_COUNT) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [ID_W-1:0] id,
  string_streamer_if.master tx,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [1:0]      dbg_state
);

  localparam int IDX_W = $clog2(MAX_LEN + 1);
  localparam int STR_W = MAX_LEN * 8;

`ifdef STRING_STREAMER_CRLF_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, FIN = 2'd2, TAIL = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, FIN = 2'd2} state_t;
`endif

  // Each message sits right-aligned in a MAX_LEN*8-bit word. Its first
  // character is therefore at the highest occupied byte.
  function automatic logic [STR_W-1:0] msg_str(input logic [ID_W-1:0] i);
    case (int'(i))
      0:       msg_str = STR_W'("starting program");
      1:       msg_str = STR_W'("\n$>");
      2:       msg_str = STR_W'("error: invalid command");
      3:       msg_str = STR_W'("PONG");
      default: msg_str = STR_W'("?");
    endcase
  endfunction

  function automatic logic [7:0] msg_len(input logic [ID_W-1:0] i);
    case (int'(i))
      0:       msg_len = 8'd16;
      1:       msg_len = 8'd3;
      2:       msg_len = 8'd22;
      3:       msg_len = 8'd4;
      default: msg_len = 8'd1;
    endcase
  endfunction

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  index_q, index_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic              bad_q, bad_d;

  logic [STR_W-1:0]  cur_str;
  logic [STR_W-1:0]  shifted;
  logic [7:0]        cur_len;
  logic [7:0]        char_pos;
  logic [7:0]        cur_char;
  logic              last_char;
  logic              id_ok;
  logic [7:0]        tx_data_c;

  // The table is read through the latched id. Changes on the id input
  // after start therefore do not affect a message already in flight.
  assign cur_str   = msg_str(id_q);
  assign cur_len   = msg_len(id_q);
  assign char_pos  = cur_len - 8'd1 - 8'(index_q);
  assign shifted   = cur_str >> {char_pos, 3'b000};
  assign cur_char  = shifted[7:0];
  assign last_char = (8'(index_q) == (cur_len - 8'd1));
  assign id_ok     = (int'(id) < MSG_COUNT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      index_q <= '0;
      id_q    <= '0;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      id_q    <= id_d;
      bad_q   <= bad_d;
    end
  end

  always_comb begin
    state_d = state_q;
    index_d = index_q;
    id_d    = id_q;
    bad_d   = bad_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          id_d    = id;
          index_d = '0;
          if (id_ok) begin
            bad_d   = 1'b0;
            state_d = SEND;
          end else begin
            bad_d   = 1'b1;
            state_d = FIN;
          end
        end
      end
      SEND: begin
        if (tx.tx_ready) begin
          if (last_char) begin
            index_d = '0;
`ifdef STRING_STREAMER_CRLF_EN
            state_d = TAIL;
`else
            state_d = FIN;
`endif
          end else begin
            index_d = index_q + IDX_W'(1);
          end
        end
      end
`ifdef STRING_STREAMER_CRLF_EN
      // index_q is reused here: 0 selects CR and 1 selects LF.
      TAIL: begin
        if (tx.tx_ready) begin
          if (index_q[0]) begin
            index_d = '0;
            state_d = FIN;
          end else begin
            index_d = IDX_W'(1);
          end
        end
      end
`endif
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode directly from registered state. After reset, tx_valid,
  // busy, done and err are therefore low, and tx_data is 8'h00.
  always_comb begin
    tx_data_c = 8'h00;
    case (state_q)
      SEND: tx_data_c = cur_char;
`ifdef STRING_STREAMER_CRLF_EN
      TAIL: tx_data_c = index_q[0] ? 8'h0A : 8'h0D;
`endif
      default: tx_data_c = 8'h00;
    endcase
  end

  assign tx.tx_data  = tx_data_c;
`ifdef STRING_STREAMER_CRLF_EN
  assign tx.tx_valid = (state_q == SEND) || (state_q == TAIL);
  assign busy        = (state_q == SEND) || (state_q == TAIL);
`else
  assign tx.tx_valid = (state_q == SEND);
  assign busy        = (state_q == SEND);
`endif
  assign done        = (state_q == FIN);
  assign err         = (state_q == FIN) && bad_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_string_streamer.sv
// tb_string_streamer
//   Directed scenarios for string_streamer with a byte scoreboard. Expected
//   characters come from the bench's own copy of the message table. They
//   are queued when a start is driven and popped by a monitor on every
//   accepted byte.
module tb_string_streamer;
  localparam int MSG_COUNT = 4;
  localparam int MAX_LEN   = 32;
  localparam int ID_W      = 3;
`ifdef STRING_STREAMER_CRLF_EN
  localparam int TAIL_N = 2;
`else
  localparam int TAIL_N = 0;
`endif

  logic            clk   = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [ID_W-1:0] id    = '0;
  logic            busy, done, err;
  logic [1:0]      dbg_state;

  string_streamer_if tx_if();

  string_streamer #(
    .MSG_COUNT (MSG_COUNT),
    .MAX_LEN   (MAX_LEN),
    .ID_W      (ID_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .id        (id),
    .tx        (tx_if),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  int         errors = 0;
  int         checks = 0;
  string      msgs[4] = '{"starting program", "\n$>", "error: invalid command", "PONG"};

  function automatic void push_msg(input int m);
    for (int k = 0; k < msgs[m].len(); k++) exp_q.push_back(msgs[m][k]);
`ifdef STRING_STREAMER_CRLF_EN
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
`endif
  endfunction

  logic       hold_pend = 1'b0;
  logic [7:0] hold_data = 8'h00;
  logic [7:0] exp_b;

  always @(negedge clk) begin
    if (!rst_n) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        checks++;
        if (tx_if.tx_valid !== 1'b1 || tx_if.tx_data !== hold_data) begin
          errors++;
          $display("FAIL hold: valid=%b data=%h, required valid=1 data=%h",
                   tx_if.tx_valid, tx_if.tx_data, hold_data);
        end
      end
      if (tx_if.tx_valid === 1'b1 && tx_if.tx_ready === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL extra_byte: got %h, required no byte", tx_if.tx_data);
        end else begin
          exp_b = exp_q.pop_front();
          if (tx_if.tx_data !== exp_b) begin
            errors++;
            $display("FAIL byte: got %h, required %h", tx_if.tx_data, exp_b);
          end
        end
      end
      hold_pend = (tx_if.tx_valid === 1'b1) && (tx_if.tx_ready !== 1'b1);
      hold_data = tx_if.tx_data;
    end
  end

  // ---------------- driver tasks ----------------
  // Start is high for exactly one cycle N. On return, the bench is just
  // past the edge that opens cycle N+1. The id input is then scrambled to
  // show that the latched id is what counts.
  task automatic do_start(input logic [ID_W-1:0] m);
    @(posedge clk); #1;
    start = 1'b1;
    id    = m;
    @(posedge clk); #1;
    start = 1'b0;
    id    = ID_W'($urandom_range(0, 7));
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    tx_if.tx_ready = 1'b1;
    start = 1'b1;
    id    = 3'd3;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (tx_if.tx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, required 0", tx_if.tx_valid); end
    checks++;
    if (tx_if.tx_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h, required 00", tx_if.tx_data); end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      errors++; $display("FAIL reset_flags: busy=%b done=%b err=%b, required 0 0 0", busy, done, err);
    end
    checks++;
    if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d, required 0", dbg_state); end
    @(posedge clk); #1;
    start = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_pong();
    int len = 4 + TAIL_N;
    push_msg(3);
    do_start(3'd3);
    for (int c = 1; c <= len + 1; c++) begin
      @(negedge clk);
      checks++;
      if (c <= len) begin
        if (tx_if.tx_valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
          errors++;
          $display("FAIL pong_cycle%0d: valid=%b busy=%b done=%b, required 1 1 0", c, tx_if.tx_valid, busy, done);
        end
      end else begin
        if (done !== 1'b1 || err !== 1'b0 || busy !== 1'b0 || tx_if.tx_valid !== 1'b0) begin
          errors++;
          $display("FAIL pong_done: done=%b err=%b busy=%b valid=%b, required 1 0 0 0", done, err, busy, tx_if.tx_valid);
        end
      end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || dbg_state !== 2'd0) begin
      errors++; $display("FAIL pong_idle: done=%b state=%0d, required 0 0", done, dbg_state);
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL pong_queue: %0d left, required 0", exp_q.size()); end
  endtask

  task automatic test_ready_toggle();
    int dcnt = 0;
    tx_if.tx_ready = 1'b1;
    push_msg(1);
    do_start(3'd1);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done === 1'b1) dcnt++;
      @(posedge clk); #1;
      tx_if.tx_ready = ~tx_if.tx_ready;
    end
    tx_if.tx_ready = 1'b1;
    checks++;
    if (dcnt != 1) begin errors++; $display("FAIL toggle_done_count: got %0d, required 1", dcnt); end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL toggle_queue: %0d left, required 0", exp_q.size()); end
  endtask

  task automatic test_busy_start();
    int dcnt = 0;
    tx_if.tx_ready = 1'b1;
    push_msg(0);
    do_start(3'd0);
    repeat (5) @(posedge clk);
    #1;
    start = 1'b1;
    id    = 3'd2;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || tx_if.tx_data !== msgs[0][5]) begin
      errors++; $display("FAIL busy_char5: busy=%b data=%h, required 1 %h", busy, tx_if.tx_data, msgs[0][5]);
    end
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done === 1'b1) dcnt++;
    end
    checks++;
    if (dcnt != 1) begin errors++; $display("FAIL busy_done_count: got %0d, required 1", dcnt); end
    checks++;
    if (exp_q.size() != 0 || dbg_state !== 2'd0) begin
      errors++; $display("FAIL busy_end: queue=%0d state=%0d, required 0 0", exp_q.size(), dbg_state);
    end
  endtask

  task automatic test_invalid();
    logic [ID_W-1:0] bad_ids[3] = '{3'd4, 3'd5, 3'd7};
    for (int i = 0; i < 3; i++) begin
      do_start(bad_ids[i]);
      @(negedge clk);
      checks++;
      if (done !== 1'b1 || err !== 1'b1 || tx_if.tx_valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL invalid_id%0d: done=%b err=%b valid=%b busy=%b, required 1 1 0 0",
                 bad_ids[i], done, err, tx_if.tx_valid, busy);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || err !== 1'b0 || dbg_state !== 2'd0) begin
        errors++;
        $display("FAIL invalid_after%0d: done=%b err=%b state=%0d, required 0 0 0", bad_ids[i], done, err, dbg_state);
      end
    end
  endtask

  task automatic test_reset_mid();
    int dcnt = 0;
    tx_if.tx_ready = 1'b1;
    push_msg(2);
    do_start(3'd2);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    if (done === 1'b1) dcnt++;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (tx_if.tx_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL midreset: valid=%b busy=%b done=%b, required 0 0 0", tx_if.tx_valid, busy, done);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (done === 1'b1) dcnt++;
    end
    checks++;
    if (dcnt != 0) begin errors++; $display("FAIL midreset_done: got %0d pulses, required 0", dcnt); end
    test_pong();
  endtask

  task automatic test_back_to_back();
    int len1 = 4 + TAIL_N;
    int len2 = 3 + TAIL_N;
    tx_if.tx_ready = 1'b1;
    push_msg(3);
    push_msg(1);
    do_start(3'd3);
    repeat (len1) @(posedge clk);
    #1;
    start = 1'b1;
    id    = 3'd1;
    @(negedge clk);
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL b2b_first_done: got %b, required 1", done); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (dbg_state !== 2'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL b2b_idle: state=%0d busy=%b, required 0 0", dbg_state, busy);
    end
    @(posedge clk); #1;
    start = 1'b0;
    id    = 3'd2;
    for (int c = 1; c <= len2 + 1; c++) begin
      @(negedge clk);
      checks++;
      if (c <= len2) begin
        if (tx_if.tx_valid !== 1'b1 || busy !== 1'b1) begin
          errors++; $display("FAIL b2b_cycle%0d: valid=%b busy=%b, required 1 1", c, tx_if.tx_valid, busy);
        end
      end else begin
        if (done !== 1'b1 || err !== 1'b0) begin
          errors++; $display("FAIL b2b_second_done: done=%b err=%b, required 1 0", done, err);
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_queue: %0d left, required 0", exp_q.size()); end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    tx_if.tx_ready = 1'b1;
    test_reset();
    test_pong();
    test_ready_toggle();
    test_busy_start();
    test_invalid();
    test_reset_mid();
    test_back_to_back();
    repeat (3) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL final_queue: %0d left, required 0", exp_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
